// File: rtl/mips_fetch_pkg.sv
// Shared constants and the next-PC select encoding for the MIPS fetch stage.
package mips_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          PC_INC           = 4;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_BRANCH,
        SEL_JUMP
    } next_pc_sel_e;

endpackage

// File: rtl/pc_register.sv
// Program counter flop, next-PC priority mux and ROM range/alignment check.
module pc_register
    import mips_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    ROM_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    input  logic                  jump_i,
    input  logic [DATA_WIDTH-1:0] jump_target_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic                  fault_now_o,
    output logic                  redirect_o
);

    // One bit wider so RESET_PC + 4*ROM_DEPTH cannot overflow the compare.
    localparam logic [DATA_WIDTH:0] PC_LIMIT =
        {1'b0, RESET_PC} + (DATA_WIDTH+1)'(4 * ROM_DEPTH);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pc_inc;
    next_pc_sel_e          next_sel;

    assign pc_inc = pc_q + DATA_WIDTH'(PC_INC);

    always_comb begin
        next_sel = SEL_SEQ;
        if (branch_taken_i) begin
            next_sel = SEL_BRANCH;
        end else if (jump_i) begin
            next_sel = SEL_JUMP;
        end else if (stall_i) begin
            next_sel = SEL_HOLD;
        end

        pc_d = pc_inc;
        case (next_sel)
            SEL_BRANCH: pc_d = branch_target_i;
            SEL_JUMP:   pc_d = jump_target_i;
            SEL_HOLD:   pc_d = pc_q;
            default:    pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_inc;
    assign redirect_o  = branch_taken_i | jump_i;
    assign fault_now_o = (pc_q[1:0] != 2'b00) ||
                         (pc_q < RESET_PC) ||
                         ({1'b0, pc_q} >= PC_LIMIT);

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, IF/ID pipeline register and sticky fetch-fault flag.
// Define FETCH_PERF_CNT_EN to add saturating fetch/stall performance counters.
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    ROM_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    input  logic                  jump_i,
    input  logic [DATA_WIDTH-1:0] jump_target_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] if_id_instr_o,
    output logic [DATA_WIDTH-1:0] if_id_pc4_o,
    output logic                  if_id_valid_o,
    output logic                  fetch_fault_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt_o,
    output logic [31:0]           perf_stall_cnt_o
`endif
);

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  fault_now;
    logic                  redirect;
    logic                  capture;

    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;

    pc_register #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC),
        .ROM_DEPTH  (ROM_DEPTH)
    ) u_pc_register (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .pc_o            (pc),
        .pc_plus4_o      (pc_plus4),
        .fault_now_o     (fault_now),
        .redirect_o      (redirect)
    );

    assign capture = !flush_i && !stall_i;

    // Flush squashes to NOP ahead of stall; a faulting fetch is captured as NOP.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if (flush_i) begin
            instr_d = DATA_WIDTH'(NOP_INSTR);
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (capture) begin
            instr_d = fault_now ? DATA_WIDTH'(NOP_INSTR) : imem_data_i;
            pc4_d   = pc_plus4;
            valid_d = !fault_now;
            fault_d = fault_q | fault_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= DATA_WIDTH'(NOP_INSTR);
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr_o   = pc;
    assign pc_o          = pc;
    assign if_id_instr_o = instr_q;
    assign if_id_pc4_o   = pc4_q;
    assign if_id_valid_o = valid_q;
    assign fetch_fault_o = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (capture && !fault_now && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stall_i && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
